// File: rtl/issue_arbiter.sv
// Issue arbiter: per-FU-port round-robin selection of ready reservation-station
// entries, with a registered EMPTY/HOLD presentation stage and an ack back to the RS.
module issue_arbiter #(
    parameter int unsigned N_ENT = 5,
    parameter int unsigned N_FU  = 4,
    localparam int unsigned IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_ENT-1:0]                 ent_ready_i,
    input  logic [N_ENT-1:0][1:0]            ent_fu_i,
    input  logic                             flush_i,
    input  logic [N_FU-1:0]                  fu_ready_i,
    output logic [N_FU-1:0]                  fu_valid_o,
    output logic [N_FU-1:0][IDX_W-1:0]       fu_idx_o,
    output logic [N_ENT-1:0]                 issue_ack_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } port_state_e;

    port_state_e                 state_q [N_FU];
    port_state_e                 state_d [N_FU];
    logic [N_FU-1:0][IDX_W-1:0]  fu_idx_q, fu_idx_d;
    logic [N_FU-1:0][IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_ENT-1:0]            ack_q, ack_d;

    logic [N_FU-1:0]             hold_s;
    logic [N_FU-1:0]             load_s;
    logic [N_FU-1:0][N_ENT-1:0]  elig_s;
    logic [N_FU-1:0]             found_s;
    logic [N_FU-1:0][IDX_W-1:0]  sel_s;
    logic [N_ENT-1:0]            issue_ack_s;

    function automatic int wrap_idx(input int v);
        return (v >= int'(N_ENT)) ? (v - int'(N_ENT)) : v;
    endfunction

    // Eligibility masks and round-robin pick per port.
    always_comb begin
        hold_s  = {N_FU{1'b0}};
        load_s  = {N_FU{1'b0}};
        elig_s  = {(N_FU*N_ENT){1'b0}};
        found_s = {N_FU{1'b0}};
        sel_s   = {(N_FU*IDX_W){1'b0}};
        for (int c = 0; c < int'(N_FU); c++) begin
            hold_s[c] = (state_q[c] == ST_HOLD);
            load_s[c] = !flush_i && (!hold_s[c] || fu_ready_i[c]);
            // The held entry is excluded so a handshake never reloads the same index.
            for (int i = 0; i < int'(N_ENT); i++) begin
                elig_s[c][i] = ent_ready_i[i] && (ent_fu_i[i] == 2'(c)) && !ack_q[i]
                               && !(hold_s[c] && (fu_idx_q[c] == IDX_W'(i)));
            end
            for (int j = 0; j < int'(N_ENT); j++) begin
                if (!found_s[c] && elig_s[c][wrap_idx(int'(rr_ptr_q[c]) + j)]) begin
                    found_s[c] = 1'b1;
                    sel_s[c]   = IDX_W'(wrap_idx(int'(rr_ptr_q[c]) + j));
                end else begin
                    found_s[c] = found_s[c];
                end
            end
        end
    end

    // Per-port EMPTY/HOLD next state, presented index and round-robin pointer.
    always_comb begin
        fu_idx_d = fu_idx_q;
        rr_ptr_d = rr_ptr_q;
        for (int c = 0; c < int'(N_FU); c++) begin
            state_d[c] = state_q[c];
            if (flush_i) begin
                state_d[c] = ST_EMPTY;
            end else if (load_s[c]) begin
                if (found_s[c]) begin
                    state_d[c]  = ST_HOLD;
                    fu_idx_d[c] = sel_s[c];
                    rr_ptr_d[c] = (sel_s[c] == IDX_W'(N_ENT - 1)) ? {IDX_W{1'b0}}
                                                                 : sel_s[c] + IDX_W'(1);
                end else begin
                    state_d[c] = ST_EMPTY;
                end
            end else begin
                state_d[c] = state_q[c];
            end
        end
    end

    // Handshake acknowledge back to the reservation station, squashed by flush.
    always_comb begin
        issue_ack_s = {N_ENT{1'b0}};
        for (int c = 0; c < int'(N_FU); c++) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                issue_ack_s[i] = issue_ack_s[i] | (hold_s[c] && fu_ready_i[c] && !flush_i
                                                   && (fu_idx_q[c] == IDX_W'(i)));
            end
        end
        ack_d = flush_i ? {N_ENT{1'b0}} : issue_ack_s;
    end

    // State, index, pointer and ack-mask registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < int'(N_FU); c++) begin
                state_q[c] <= ST_EMPTY;
            end
            fu_idx_q <= {(N_FU*IDX_W){1'b0}};
            rr_ptr_q <= {(N_FU*IDX_W){1'b0}};
            ack_q    <= {N_ENT{1'b0}};
        end else begin
            for (int c = 0; c < int'(N_FU); c++) begin
                state_q[c] <= state_d[c];
            end
            fu_idx_q <= fu_idx_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
        end
    end

    assign fu_valid_o  = hold_s;
    assign fu_idx_o    = fu_idx_q;
    assign issue_ack_o = issue_ack_s;

endmodule
